// File: rtl/axi_sdram_memtest_master.sv
// AXI4 burst master that fills an SDRAM region with a pattern and reads it back.
// Define MEMTEST_LFSR_PATTERN_EN for LFSR data instead of the beat-address pattern.
module axi_sdram_memtest_master #(
    parameter int          C_BURST_LEN = 16,
    parameter logic [31:0] C_SEED      = 32'h1
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_aresetn,
    input  logic        start,
    input  logic [24:0] base_addr,
    input  logic [15:0] num_bursts,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] err_count,
    output logic [24:0] first_err_addr,
    output logic        m_axi_awid,
    output logic [24:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awlock,
    output logic [3:0]  m_axi_awcache,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic        m_axi_bid,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic        m_axi_arid,
    output logic [24:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arlock,
    output logic [3:0]  m_axi_arcache,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic        m_axi_rid,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);
    localparam logic [24:0] STEP = 25'(C_BURST_LEN * 4);
    localparam logic [7:0]  LAST = 8'(C_BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [24:0] base_q, addr_q, beat_addr;
    logic [15:0] nb_q, burst_cnt;
    logic [7:0]  beat_cnt;
    logic [31:0] pattern;
    logic        last_beat, last_burst, r_hs, fail_b, fail_r;
    logic        unused_ids;

    assign unused_ids = m_axi_bid ^ m_axi_rid;
    assign beat_addr  = addr_q + {15'd0, beat_cnt, 2'b00};
    assign last_beat  = beat_cnt == LAST;
    assign last_burst = burst_cnt == nb_q - 16'd1;
    assign r_hs       = (state == RD_DATA) && m_axi_rvalid;
    assign fail_b     = (state == WR_RESP) && m_axi_bvalid &&
                        (m_axi_bresp != 2'b00);
    assign fail_r     = r_hs && ((m_axi_rdata != pattern) ||
                        (m_axi_rresp != 2'b00) ||
                        (m_axi_rlast != last_beat));

    assign busy          = (state != IDLE) && (state != DONE);
    assign m_axi_awid    = 1'b0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = LAST;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = state == WR_ADDR;
    assign m_axi_wdata   = pattern;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = state == WR_DATA;
    assign m_axi_wlast   = m_axi_wvalid && last_beat;
    assign m_axi_bready  = state == WR_RESP;
    assign m_axi_arid    = 1'b0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = LAST;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = state == RD_ADDR;
    assign m_axi_rready  = state == RD_DATA;

`ifdef MEMTEST_LFSR_PATTERN_EN
    logic [31:0] lfsr;
    logic        w_hs;

    assign w_hs    = m_axi_wvalid && m_axi_wready;
    assign pattern = lfsr;

    // Reseeded when the read phase begins so reads replay the write sequence
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn)
            lfsr <= 32'd0;
        else if ((state == IDLE) && start)
            lfsr <= C_SEED;
        else if ((state == WR_RESP) && m_axi_bvalid && last_burst)
            lfsr <= C_SEED;
        else if (w_hs || r_hs)
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'd0);
    end
`else
    logic unused_seed;

    assign unused_seed = ^C_SEED;
    assign pattern     = {7'd0, beat_addr};
`endif

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)
                         state_nxt = (num_bursts == 16'd0) ? DONE : WR_ADDR;
            WR_ADDR: if (m_axi_awready) state_nxt = WR_DATA;
            WR_DATA: if (m_axi_wready && last_beat) state_nxt = WR_RESP;
            WR_RESP: if (m_axi_bvalid)
                         state_nxt = last_burst ? RD_ADDR : WR_ADDR;
            RD_ADDR: if (m_axi_arready) state_nxt = RD_DATA;
            RD_DATA: if (m_axi_rvalid && last_beat)
                         state_nxt = last_burst ? DONE : RD_ADDR;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            base_q    <= '0;
            addr_q    <= '0;
            nb_q      <= '0;
            burst_cnt <= '0;
            beat_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base_q    <= {base_addr[24:2], 2'b00};
                    addr_q    <= {base_addr[24:2], 2'b00};
                    nb_q      <= num_bursts;
                    burst_cnt <= '0;
                    beat_cnt  <= '0;
                    done      <= num_bursts == 16'd0;
                end
                WR_DATA: if (m_axi_wready)
                    beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
                WR_RESP: if (m_axi_bvalid) begin
                    if (last_burst) begin
                        burst_cnt <= '0;
                        addr_q    <= base_q;
                    end else begin
                        burst_cnt <= burst_cnt + 16'd1;
                        addr_q    <= addr_q + STEP;
                    end
                end
                RD_DATA: if (m_axi_rvalid) begin
                    beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
                    if (last_beat) begin
                        if (last_burst) begin
                            done <= 1'b1;
                        end else begin
                            burst_cnt <= burst_cnt + 16'd1;
                            addr_q    <= addr_q + STEP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            error          <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if ((state == IDLE) && start) begin
            error          <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (fail_b || fail_r) begin
            error <= 1'b1;
            if (!error)
                first_err_addr <= fail_b ? addr_q : beat_addr;
            if (err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_axi_sdram_memtest_master.sv
// Testbench for axi_sdram_memtest_master: negedge AXI slave model with
// memory, fault injection and a burst-level expected-result model.
module tb_axi_sdram_memtest_master;
    localparam int LEN = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [24:0] base_addr = '0;
    logic [15:0] num_bursts = '0;
    logic        busy, done, error;
    logic [15:0] err_count;
    logic [24:0] first_err_addr;
    logic        m_axi_awid, m_axi_awlock, m_axi_awvalid;
    logic [24:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize, m_axi_awprot;
    logic [1:0]  m_axi_awburst;
    logic [3:0]  m_axi_awcache;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic        m_axi_bid = 1'b1;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic        m_axi_arid, m_axi_arlock, m_axi_arvalid;
    logic [24:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize, m_axi_arprot;
    logic [1:0]  m_axi_arburst;
    logic [3:0]  m_axi_arcache;
    logic        m_axi_arready = 1'b0;
    logic        m_axi_rid = 1'b1;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    axi_sdram_memtest_master #(.C_BURST_LEN(LEN), .C_SEED(32'h1)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .start(start), .base_addr(base_addr), .num_bursts(num_bursts),
        .busy(busy), .done(done), .error(error),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // slave configuration
    int aw_delay = 0;
    bit w_toggle = 0;
    bit rand_rdy = 0;
    int bad_b = -1;
    int bad_beat = -1;
    int bad_last = -1;

    // per-run observations
    logic [31:0] mem [int];
    logic [24:0] aw_q [$];
    logic [24:0] ar_q [$];
    logic [31:0] wd_q [$];
    int wlast_cnt, b_cnt, r_total, valid_cnt, stab_err, attr_err;

    // slave internal state
    bit aw_f, w_f, b_f, ar_f, r_f;
    logic [24:0] aw_s, ar_s, aw_hold, ar_hold, wbase, rbase;
    logic [31:0] wd_s;
    logic wl_s;
    logic [32:0] w_hold;
    bit w_act, r_act, b_pend, aw_stall, w_stall, ar_stall;
    int wbeat, rbeat, awcnt, rk;

    always @(negedge clk) begin
        if (!rst_n) begin
            {aw_f, w_f, b_f, ar_f, r_f} = '0;
            {w_act, r_act, b_pend} = '0;
            {aw_stall, w_stall, ar_stall} = '0;
            awcnt = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
        end else begin
            if (aw_f) begin
                aw_q.push_back(aw_s);
                w_act = 1; wbase = aw_s; wbeat = 0; awcnt = 0;
            end
            if (w_f) begin
                mem[int'(wbase) + 4 * wbeat] = wd_s;
                wd_q.push_back(wd_s);
                if (wl_s) wlast_cnt++;
                wbeat++;
                if (wbeat == LEN) begin w_act = 0; b_pend = 1; end
            end
            if (b_f) begin b_pend = 0; b_cnt++; end
            if (ar_f) begin
                ar_q.push_back(ar_s);
                r_act = 1; rbase = ar_s; rbeat = 0;
            end
            if (r_f) begin
                r_total++; rbeat++;
                if (rbeat == LEN) r_act = 0;
            end
            m_axi_bvalid = b_pend;
            m_axi_bresp = (b_cnt == bad_b) ? 2'b10 : 2'b00;
            if (r_act && (!rand_rdy || $urandom_range(3) != 0)) begin
                rk = int'(rbase) + 4 * rbeat;
                m_axi_rvalid = 1;
                m_axi_rdata = (mem.exists(rk) ? mem[rk] : 32'd0) ^
                              ((r_total == bad_beat) ? 32'd1 : 32'd0);
                m_axi_rlast = (rbeat == LEN - 1) ^ (r_total == bad_last);
            end else begin
                m_axi_rvalid = 0;
                m_axi_rlast = 0;
            end
            if (m_axi_awvalid) awcnt++;
            m_axi_awready = m_axi_awvalid && (awcnt > aw_delay) &&
                            (!rand_rdy || $urandom_range(1) == 1);
            if (w_toggle) m_axi_wready = !m_axi_wready;
            else m_axi_wready = !rand_rdy || ($urandom_range(1) == 1);
            m_axi_arready = !rand_rdy || ($urandom_range(1) == 1);

            if (aw_stall && (!m_axi_awvalid || m_axi_awaddr !== aw_hold))
                stab_err++;
            if (ar_stall && (!m_axi_arvalid || m_axi_araddr !== ar_hold))
                stab_err++;
            if (w_stall && (!m_axi_wvalid ||
                {m_axi_wlast, m_axi_wdata} !== w_hold))
                stab_err++;
            if (m_axi_awvalid && ({m_axi_awid, m_axi_awlen, m_axi_awsize,
                m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot} !==
                {1'b0, 8'(LEN - 1), 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000}))
                attr_err++;
            if (m_axi_arvalid && ({m_axi_arid, m_axi_arlen, m_axi_arsize,
                m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot} !==
                {1'b0, 8'(LEN - 1), 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000}))
                attr_err++;
            if (m_axi_wvalid && m_axi_wstrb !== 4'hF) attr_err++;
            if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) valid_cnt++;

            aw_f = m_axi_awvalid && m_axi_awready;
            aw_stall = m_axi_awvalid && !m_axi_awready;
            aw_s = m_axi_awaddr; aw_hold = m_axi_awaddr;
            ar_f = m_axi_arvalid && m_axi_arready;
            ar_stall = m_axi_arvalid && !m_axi_arready;
            ar_s = m_axi_araddr; ar_hold = m_axi_araddr;
            w_f = m_axi_wvalid && m_axi_wready;
            w_stall = m_axi_wvalid && !m_axi_wready;
            wd_s = m_axi_wdata; wl_s = m_axi_wlast;
            w_hold = {m_axi_wlast, m_axi_wdata};
            b_f = m_axi_bvalid && m_axi_bready;
            r_f = m_axi_rvalid && m_axi_rready;
        end
    end

    task automatic clear_mon();
        aw_q.delete(); ar_q.delete(); wd_q.delete();
        wlast_cnt = 0; b_cnt = 0; r_total = 0;
        valid_cnt = 0; stab_err = 0; attr_err = 0;
    endtask

    // Starts one run and waits for done; cyc = -1 on timeout.
    task automatic run_op(input logic [24:0] b, input logic [15:0] n,
                          output bit lat_ok, output int cyc);
        @(posedge clk);
        clear_mon();
        @(negedge clk);
        base_addr = b; num_bursts = n; start = 1;
        @(negedge clk);
        start = 0;
        lat_ok = (busy === 1'b1) && (m_axi_awvalid === 1'b1);
        cyc = -1;
        for (int i = 1; i < 4000; i++) begin
            if (done === 1'b1) begin cyc = i; break; end
            @(negedge clk);
        end
    endtask

    // Expected error count and first failing address from the fault plan.
    task automatic model(input logic [24:0] b, input int n,
                         output logic [15:0] ec, output logic [24:0] fa);
        int g = 0;
        ec = 0; fa = 0;
        for (int i = 0; i < n; i++)
            if (i == bad_b) begin
                if (ec == 0) fa = b + 25'(i * LEN * 4);
                ec++;
            end
        for (int i = 0; i < n; i++)
            for (int k = 0; k < LEN; k++) begin
                if (g == bad_beat || g == bad_last) begin
                    if (ec == 0) fa = b + 25'(i * LEN * 4 + 4 * k);
                    ec++;
                end
                g++;
            end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, error, err_count, first_err_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_status: got %0h want 0",
                     {busy, done, error, err_count, first_err_addr});
        end
        n_cmp++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
             m_axi_rready, m_axi_wlast} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got %b want 0",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                      m_axi_bready, m_axi_rready, m_axi_wlast});
        end
        n_cmp++;
        if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: got %0h want 0",
                     {m_axi_awaddr, m_axi_araddr, m_axi_wdata});
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_clean_pass();
        bit lat; int cyc;
        logic [31:0] exp;
        run_op(25'h40, 16'd2, lat, cyc);
        n_cmp++;
        if (cyc < 0) begin n_fail++; $display("FAIL clean_timeout: done never rose"); end
        n_cmp++;
        if (!lat) begin n_fail++; $display("FAIL clean_latency: busy/awvalid got 0 want 1"); end
        n_cmp++;
        if (aw_q.size() != 2 || aw_q[0] !== 25'h40 || aw_q[1] !== 25'h80) begin
            n_fail++;
            $display("FAIL clean_awaddr: got %0d bursts want 2 at 40,80", aw_q.size());
        end
        n_cmp++;
        if (ar_q.size() != 2 || ar_q[0] !== 25'h40 || ar_q[1] !== 25'h80) begin
            n_fail++;
            $display("FAIL clean_araddr: got %0d bursts want 2 at 40,80", ar_q.size());
        end
        n_cmp++;
        if (wd_q.size() != 2 * LEN || wlast_cnt != 2) begin
            n_fail++;
            $display("FAIL clean_wcount: got %0d beats %0d wlast want 32 / 2",
                     wd_q.size(), wlast_cnt);
        end
        for (int i = 0; i < wd_q.size(); i++) begin
            exp = {7'd0, 25'h40 + 25'(4 * i)};
            n_cmp++;
            if (wd_q[i] !== exp) begin
                n_fail++;
                $display("FAIL clean_wdata[%0d]: got %0h want %0h", i, wd_q[i], exp);
            end
        end
        n_cmp++;
        if ({done, error, busy, err_count} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL clean_status: got d%b e%b b%b c%0d want d1 e0 b0 c0",
                     done, error, busy, err_count);
        end
        n_cmp++;
        if (attr_err != 0) begin
            n_fail++;
            $display("FAIL clean_attrs: got %0d bad beats want 0", attr_err);
        end
    endtask

    task automatic test_corruption();
        bit lat; int cyc;
        bad_beat = 5;
        run_op(25'h0, 16'd1, lat, cyc);
        bad_beat = -1;
        n_cmp++;
        if (cyc < 0 || {error, err_count, first_err_addr} !==
            {1'b1, 16'd1, 25'h14}) begin
            n_fail++;
            $display("FAIL corrupt: got e%b c%0d a%0h want e1 c1 a14",
                     error, err_count, first_err_addr);
        end
    endtask

    task automatic test_backpressure();
        bit lat; int cyc;
        aw_delay = 3; w_toggle = 1;
        run_op(25'h100, 16'd1, lat, cyc);
        aw_delay = 0; w_toggle = 0;
        n_cmp++;
        if (stab_err != 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err);
        end
        n_cmp++;
        if (wd_q.size() != LEN || wlast_cnt != 1) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d beats %0d wlast want 16 / 1",
                     wd_q.size(), wlast_cnt);
        end
        n_cmp++;
        if (cyc < 0 || done !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_result: got d%b e%b want d1 e0", done, error);
        end
    endtask

    task automatic test_bad_resp();
        bit lat; int cyc;
        bad_b = 0;
        run_op(25'h200, 16'd1, lat, cyc);
        bad_b = -1;
        n_cmp++;
        if (cyc < 0 || {error, err_count, first_err_addr} !==
            {1'b1, 16'd1, 25'h200}) begin
            n_fail++;
            $display("FAIL bresp: got e%b c%0d a%0h want e1 c1 a200",
                     error, err_count, first_err_addr);
        end
        n_cmp++;
        if (ar_q.size() != 1) begin
            n_fail++;
            $display("FAIL bresp_read: got %0d AR want 1", ar_q.size());
        end
    endtask

    task automatic test_zero_len();
        bit lat; int cyc;
        run_op(25'h40, 16'd0, lat, cyc);
        n_cmp++;
        if (cyc < 0 || cyc > 2) begin
            n_fail++;
            $display("FAIL zero_done: got %0d cycles want <=2", cyc);
        end
        n_cmp++;
        if (valid_cnt != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_traffic: got %0d valid cycles busy %b want 0 / 0",
                     valid_cnt, busy);
        end
    endtask

    task automatic test_wrap();
        bit lat; int cyc;
        run_op(25'h1FFFFC0, 16'd2, lat, cyc);
        n_cmp++;
        if (aw_q.size() != 2 || aw_q[0] !== 25'h1FFFFC0 || aw_q[1] !== 25'h0) begin
            n_fail++;
            $display("FAIL wrap_awaddr: got %0d bursts want 1FFFFC0,0", aw_q.size());
        end
        n_cmp++;
        if (cyc < 0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_result: got e%b want e0", error);
        end
    endtask

    task automatic test_rlast();
        bit lat; int cyc;
        bad_last = 20;
        run_op(25'h400, 16'd2, lat, cyc);
        bad_last = -1;
        n_cmp++;
        if (cyc < 0 || {err_count, first_err_addr} !== {16'd1, 25'h450}) begin
            n_fail++;
            $display("FAIL rlast: got c%0d a%0h want c1 a450",
                     err_count, first_err_addr);
        end
    endtask

    task automatic test_reset_mid();
        bit lat; int cyc;
        @(posedge clk);
        clear_mon();
        @(negedge clk);
        base_addr = 25'h0; num_bursts = 16'd2; start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 200 && wd_q.size() < 3; i++) @(negedge clk);
        n_cmp++;
        if (wd_q.size() < 3) begin
            n_fail++;
            $display("FAIL rstmid_wait: got %0d beats want >=3", wd_q.size());
        end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b want 0",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || m_axi_awvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle: got busy %b awvalid %b want 0 / 0",
                     busy, m_axi_awvalid);
        end
        run_op(25'h80, 16'd1, lat, cyc);
        n_cmp++;
        if (cyc < 0 || error !== 1'b0 || wd_q.size() != LEN) begin
            n_fail++;
            $display("FAIL rstmid_rerun: got e%b beats %0d want e0 16",
                     error, wd_q.size());
        end
    endtask

    task automatic test_random();
        bit lat; int cyc, n;
        logic [24:0] b, fa;
        logic [15:0] ec;
        logic [31:0] exp;
        rand_rdy = 1;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(4, 1);
            b = 25'($urandom) & 25'h1FFFFC0;
            bad_b = int'($urandom_range(5, 0)) - 1;
            bad_beat = $urandom_range(n * LEN * 2, 0);
            bad_last = $urandom_range(n * LEN * 2, 0);
            model(b, n, ec, fa);
            run_op(b, 16'(n), lat, cyc);
            n_cmp++;
            if (cyc < 0 || {error, err_count, first_err_addr} !==
                {ec != 0, ec, fa}) begin
                n_fail++;
                $display("FAIL rand%0d_result: got e%b c%0d a%0h want e%b c%0d a%0h",
                         it, error, err_count, first_err_addr, ec != 0, ec, fa);
            end
            n_cmp++;
            if (aw_q.size() != n || ar_q.size() != n || wd_q.size() != n * LEN ||
                stab_err != 0 || attr_err != 0) begin
                n_fail++;
                $display("FAIL rand%0d_traffic: got aw%0d ar%0d w%0d stab%0d attr%0d want %0d/%0d/%0d/0/0",
                         it, aw_q.size(), ar_q.size(), wd_q.size(), stab_err,
                         attr_err, n, n, n * LEN);
            end
            for (int i = 0; i < aw_q.size(); i++) begin
                n_cmp++;
                if (aw_q[i] !== b + 25'(i * LEN * 4)) begin
                    n_fail++;
                    $display("FAIL rand%0d_aw[%0d]: got %0h want %0h",
                             it, i, aw_q[i], b + 25'(i * LEN * 4));
                end
            end
            for (int i = 0; i < wd_q.size(); i++) begin
                exp = {7'd0, b + 25'(4 * i)};
                n_cmp++;
                if (wd_q[i] !== exp) begin
                    n_fail++;
                    $display("FAIL rand%0d_wd[%0d]: got %0h want %0h",
                             it, i, wd_q[i], exp);
                end
            end
        end
        rand_rdy = 0; bad_b = -1; bad_beat = -1; bad_last = -1;
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_corruption();
        test_backpressure();
        test_bad_resp();
        test_zero_len();
        test_wrap();
        test_rlast();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
